// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with tkeep/tlast, first-word fall-through (push on edge N -> valid in cycle N+1).
// Backpressure: s_axis_tready drops only when full; optional store-and-forward releases whole frames.
module axis_pkt_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [$clog2(DEPTH):0]     pkt_count,
  output logic                       overflow_release
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [0:0] ST_HOLD  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] occ_q, occ_d;
  logic [PW-1:0] pkt_q, pkt_d;
  logic [0:0]    state_q, state_d;
  logic          full, empty, push, pop, flush_start, release_ok;
  entry_t        head;

  always_comb begin
    // Pointer MSBs differ with equal indices only after exactly DEPTH more writes than reads.
    full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty       = (wr_ptr_q == rd_ptr_q);
    head        = mem_q[rd_ptr_q[AW-1:0]];
    flush_start = (PACKET_MODE != 0) && (state_q == ST_HOLD) && full && (pkt_q == '0);
    if ((PACKET_MODE == 0) || (state_q == ST_FLUSH)) begin
      release_ok = !empty;
    end else begin
      release_ok = (pkt_q != '0);
    end
  end

  assign s_axis_tready    = !areset && !full;
  assign m_axis_tvalid    = !areset && release_ok;
  assign overflow_release = !areset && flush_start;
  assign m_axis_tdata     = head.tdata;
  assign m_axis_tkeep     = head.tkeep;
  assign m_axis_tlast     = head.tlast;
  assign occupancy        = occ_q;
  assign pkt_count        = pkt_q;

  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = m_axis_tvalid && m_axis_tready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    occ_d    = occ_q + PW'(push) - PW'(pop);
    pkt_d    = pkt_q + PW'(push && s_axis_tlast) - PW'(pop && head.tlast);
    state_d  = state_q;
    // A frame longer than the FIFO can never complete in HOLD, so stream it out instead.
    if (flush_start) begin
      state_d = ST_FLUSH;
    end else if ((state_q == ST_FLUSH) && pop && head.tlast) begin
      state_d = ST_HOLD;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pkt_q    <= '0;
      state_q  <= ST_HOLD;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pkt_q    <= pkt_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{tdata: s_axis_tdata, tkeep: s_axis_tkeep, tlast: s_axis_tlast};
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench: cut-through FIFO (DEPTH 16) and store-and-forward FIFO (DEPTH 8) against a queue model.
module tb_axis_pkt_fifo;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] s0_dat = '0, m0_dat;
  logic [3:0]  s0_keep = '0, m0_keep;
  logic        s0_last = 1'b0, s0_vld = 1'b0, s0_rdy, m0_last, m0_vld, m0_rdy = 1'b0, ovf0;
  logic [4:0]  occ0, pkt0;

  logic [31:0] s1_dat = '0, m1_dat;
  logic [3:0]  s1_keep = '0, m1_keep;
  logic        s1_last = 1'b0, s1_vld = 1'b0, s1_rdy, m1_last, m1_vld, m1_rdy = 1'b0, ovf1;
  logic [3:0]  occ1, pkt1;

  int total = 0;
  int bad   = 0;

  beat_t q0[$];
  beat_t q1[$];
  bit    fl1 = 1'b0;
  int    push1 = 0;
  int    pop1  = 0;

  always #5 clk = ~clk;

  axis_pkt_fifo #(.DATA_WIDTH(32), .DEPTH(16), .PACKET_MODE(0)) u_ct (
    .aclk(clk), .areset(rst),
    .s_axis_tdata(s0_dat), .s_axis_tkeep(s0_keep), .s_axis_tlast(s0_last),
    .s_axis_tvalid(s0_vld), .s_axis_tready(s0_rdy),
    .m_axis_tdata(m0_dat), .m_axis_tkeep(m0_keep), .m_axis_tlast(m0_last),
    .m_axis_tvalid(m0_vld), .m_axis_tready(m0_rdy),
    .occupancy(occ0), .pkt_count(pkt0), .overflow_release(ovf0)
  );

  axis_pkt_fifo #(.DATA_WIDTH(32), .DEPTH(8), .PACKET_MODE(1)) u_sf (
    .aclk(clk), .areset(rst),
    .s_axis_tdata(s1_dat), .s_axis_tkeep(s1_keep), .s_axis_tlast(s1_last),
    .s_axis_tvalid(s1_vld), .s_axis_tready(s1_rdy),
    .m_axis_tdata(m1_dat), .m_axis_tkeep(m1_keep), .m_axis_tlast(m1_last),
    .m_axis_tvalid(m1_vld), .m_axis_tready(m1_rdy),
    .occupancy(occ1), .pkt_count(pkt1), .overflow_release(ovf1)
  );

  function automatic int cnt0();
    int n = 0;
    foreach (q0[i]) if (q0[i].l) n++;
    return n;
  endfunction

  function automatic int cnt1();
    int n = 0;
    foreach (q1[i]) if (q1[i].l) n++;
    return n;
  endfunction

  // Expected {tvalid, tready, overflow, occupancy, pkt_count}.
  function automatic logic [12:0] exp0();
    return {!rst && q0.size() != 0, !rst && q0.size() != 16, 1'b0, 5'(q0.size()), 5'(cnt0())};
  endfunction

  function automatic logic [10:0] exp1();
    int  pk = cnt1();
    logic v = !rst && (fl1 ? q1.size() != 0 : pk != 0);
    return {v, !rst && q1.size() != 8, !rst && !fl1 && q1.size() == 8 && pk == 0,
            4'(q1.size()), 4'(pk)};
  endfunction

  // Frame-level model: a queue per FIFO; the packet FIFO releases only whole frames
  // unless a frame fills it with no tlast stored, in which case it streams until that tlast leaves.
  always @(posedge clk) begin : model
    beat_t h;
    int    pk;
    bit    p, o, ov;
    if (rst) begin
      q0.delete();
      q1.delete();
      fl1 = 1'b0;
    end else begin
      p = s0_vld && q0.size() != 16;
      o = m0_rdy && q0.size() != 0;
      if (o) void'(q0.pop_front());
      if (p) q0.push_back(beat_t'({s0_dat, s0_keep, s0_last}));
      pk = cnt1();
      o  = m1_rdy && (fl1 ? q1.size() != 0 : pk != 0);
      ov = !fl1 && q1.size() == 8 && pk == 0;
      p  = s1_vld && q1.size() != 8;
      if (o) begin
        h = q1.pop_front();
        pop1++;
        if (fl1 && h.l) fl1 = 1'b0;
      end else if (ov) begin
        fl1 = 1'b1;
      end
      if (p) begin
        q1.push_back(beat_t'({s1_dat, s1_keep, s1_last}));
        push1++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({m0_vld, s0_rdy, ovf0, occ0, pkt0} !== 13'h0) begin
      bad++; $display("FAIL reset_ct got=%h want=0", {m0_vld, s0_rdy, ovf0, occ0, pkt0});
    end
    total++;
    if ({m1_vld, s1_rdy, ovf1, occ1, pkt1} !== 11'h0) begin
      bad++; $display("FAIL reset_sf got=%h want=0", {m1_vld, s1_rdy, ovf1, occ1, pkt1});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({s0_rdy, s1_rdy, m0_vld, m1_vld} !== 4'b1100) begin
      bad++; $display("FAIL reset_release got=%b want=1100", {s0_rdy, s1_rdy, m0_vld, m1_vld});
    end
  endtask

  task automatic test_single();
    s0_dat = 32'h11223344; s0_keep = 4'hF; s0_last = 1'b1; s0_vld = 1'b1; m0_rdy = 1'b1;
    @(negedge clk);
    s0_vld = 1'b0;
    total++;
    if ({m0_vld, m0_dat, m0_keep, m0_last} !== {1'b1, 32'h11223344, 4'hF, 1'b1}) begin
      bad++; $display("FAIL single_data got=%b/%h/%h/%b want=1/11223344/f/1", m0_vld, m0_dat, m0_keep, m0_last);
    end
    total++;
    if ({occ0, pkt0} !== {5'd1, 5'd1}) begin
      bad++; $display("FAIL single_counts got=%0d/%0d want=1/1", occ0, pkt0);
    end
    @(negedge clk);
    total++;
    if ({m0_vld, occ0, pkt0} !== 11'h0) begin
      bad++; $display("FAIL single_drained got=%b/%0d/%0d want=0/0/0", m0_vld, occ0, pkt0);
    end
  endtask

  task automatic test_fill_drain();
    for (int r = 0; r < 3; r++) begin
      m0_rdy = 1'b0;
      for (int i = 0; i < 16; i++) begin
        s0_dat = 32'(r * 16 + i); s0_keep = 4'($urandom); s0_last = (i == 15); s0_vld = 1'b1;
        @(negedge clk);
        total++;
        if ({m0_vld, s0_rdy, ovf0, occ0, pkt0} !== exp0()) begin
          bad++; $display("FAIL fill_status r=%0d i=%0d got=%h want=%h", r, i, {m0_vld, s0_rdy, ovf0, occ0, pkt0}, exp0());
        end
      end
      total++;
      if ({s0_rdy, occ0} !== {1'b0, 5'd16}) begin
        bad++; $display("FAIL full_flag r=%0d got rdy=%b occ=%0d want rdy=0 occ=16", r, s0_rdy, occ0);
      end
      // Pop while full: the offered word must be refused.
      s0_dat = 32'hDEAD_BEEF; s0_vld = 1'b1; m0_rdy = 1'b1;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        s0_vld = 1'b0;
        total++;
        if ({m0_vld, s0_rdy, ovf0, occ0, pkt0} !== exp0()) begin
          bad++; $display("FAIL drain_status r=%0d i=%0d got=%h want=%h", r, i, {m0_vld, s0_rdy, ovf0, occ0, pkt0}, exp0());
        end
        if (q0.size() != 0) begin
          total++;
          if ({m0_dat, m0_keep, m0_last} !== q0[0]) begin
            bad++; $display("FAIL drain_data r=%0d i=%0d got=%h want=%h", r, i, {m0_dat, m0_keep, m0_last}, q0[0]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int pops = 0;
    m0_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s0_dat = $urandom; s0_keep = 4'($urandom); s0_last = 1'($urandom); s0_vld = 1'b1;
      @(negedge clk);
      if (m0_vld) pops++;
      total++;
      if ({m0_vld, s0_rdy, ovf0, occ0, pkt0} !== exp0() || occ0 !== 5'd1) begin
        bad++; $display("FAIL b2b_status i=%0d got=%h want=%h", i, {m0_vld, s0_rdy, ovf0, occ0, pkt0}, exp0());
      end
      if (q0.size() != 0) begin
        total++;
        if ({m0_dat, m0_keep, m0_last} !== q0[0]) begin
          bad++; $display("FAIL b2b_data i=%0d got=%h want=%h", i, {m0_dat, m0_keep, m0_last}, q0[0]);
        end
      end
    end
    s0_vld = 1'b0;
    @(negedge clk);
    if (m0_vld) pops++;
    total++;
    if (pops != 100 || occ0 !== 5'd0) begin
      bad++; $display("FAIL b2b_rate got pops=%0d occ=%0d want pops=100 occ=0", pops, occ0);
    end
  endtask

  task automatic test_pkt_hold();
    int first = -1, lastv = -1, vcnt = 0;
    m1_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s1_dat = $urandom; s1_keep = 4'($urandom); s1_last = 1'b0;
      s1_vld = (i < 3);
      @(negedge clk);
      total++;
      if ({m1_vld, s1_rdy, ovf1, occ1, pkt1} !== exp1() || m1_vld !== 1'b0) begin
        bad++; $display("FAIL hold_status i=%0d got=%h want=%h", i, {m1_vld, s1_rdy, ovf1, occ1, pkt1}, exp1());
      end
    end
    s1_dat = $urandom; s1_last = 1'b1; s1_vld = 1'b1;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      s1_vld = 1'b0;
      total++;
      if ({m1_vld, s1_rdy, ovf1, occ1, pkt1} !== exp1()) begin
        bad++; $display("FAIL release_status j=%0d got=%h want=%h", j, {m1_vld, s1_rdy, ovf1, occ1, pkt1}, exp1());
      end
      if (m1_vld) begin
        vcnt++;
        if (first < 0) first = j;
        lastv = j;
        total++;
        if (q1.size() == 0 || {m1_dat, m1_keep, m1_last} !== q1[0]) begin
          bad++; $display("FAIL release_data j=%0d got=%h", j, {m1_dat, m1_keep, m1_last});
        end
      end
    end
    total++;
    if (vcnt != 4 || first != 0 || lastv != 3) begin
      bad++; $display("FAIL release_burst got cnt=%0d first=%0d last=%0d want 4/0/3", vcnt, first, lastv);
    end
  endtask

  task automatic test_overflow();
    beat_t arr[12];
    int    ovc = 0, obs = 0;
    for (int i = 0; i < 12; i++) arr[i] = beat_t'({32'($urandom), 4'($urandom), i == 11});
    push1 = 0; pop1 = 0; m1_rdy = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (push1 < 12) begin
        {s1_dat, s1_keep, s1_last} = arr[push1]; s1_vld = 1'b1;
      end else begin
        s1_vld = 1'b0;
      end
      @(negedge clk);
      total++;
      if ({m1_vld, s1_rdy, ovf1, occ1, pkt1} !== exp1()) begin
        bad++; $display("FAIL ovf_status c=%0d got=%h want=%h", c, {m1_vld, s1_rdy, ovf1, occ1, pkt1}, exp1());
      end
      if (ovf1) ovc++;
      if (m1_vld && obs < 12) begin
        total++;
        if ({m1_dat, m1_keep, m1_last} !== arr[obs]) begin
          bad++; $display("FAIL ovf_order beat=%0d got=%h want=%h", obs, {m1_dat, m1_keep, m1_last}, arr[obs]);
        end
        obs++;
      end
      if (push1 == 12 && pop1 == 12) break;
    end
    s1_vld = 1'b0;
    total++;
    if (ovc != 1 || obs != 12 || m1_vld !== 1'b0 || occ1 !== 4'd0) begin
      bad++; $display("FAIL ovf_summary got pulses=%0d beats=%0d vld=%b occ=%0d want 1/12/0/0", ovc, obs, m1_vld, occ1);
    end
  endtask

  task automatic test_reset_mid();
    beat_t arr[2];
    int    obs = 0;
    m1_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s1_dat = $urandom; s1_keep = 4'($urandom); s1_last = 1'b0; s1_vld = 1'b1;
      @(negedge clk);
      total++;
      if ({m1_vld, s1_rdy, ovf1, occ1, pkt1} !== exp1()) begin
        bad++; $display("FAIL mid_fill i=%0d got=%h want=%h", i, {m1_vld, s1_rdy, ovf1, occ1, pkt1}, exp1());
      end
    end
    total++;
    if (occ1 !== 4'd5) begin
      bad++; $display("FAIL mid_occ got=%0d want=5", occ1);
    end
    rst = 1'b1; s1_vld = 1'b0;
    @(negedge clk);
    total++;
    if ({m1_vld, occ1, pkt1, occ0, pkt0} !== 19'h0) begin
      bad++; $display("FAIL mid_reset got vld=%b occ=%0d pkt=%0d", m1_vld, occ1, pkt1);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) arr[i] = beat_t'({32'($urandom), 4'($urandom), i == 1});
    m1_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 2) begin
        {s1_dat, s1_keep, s1_last} = arr[c]; s1_vld = 1'b1;
      end else begin
        s1_vld = 1'b0;
      end
      @(negedge clk);
      total++;
      if ({m1_vld, s1_rdy, ovf1, occ1, pkt1} !== exp1()) begin
        bad++; $display("FAIL post_reset c=%0d got=%h want=%h", c, {m1_vld, s1_rdy, ovf1, occ1, pkt1}, exp1());
      end
      if (m1_vld) begin
        total++;
        if (obs >= 2 || {m1_dat, m1_keep, m1_last} !== arr[obs]) begin
          bad++; $display("FAIL post_reset_data beat=%0d got=%h", obs, {m1_dat, m1_keep, m1_last});
        end
        obs++;
      end
    end
    total++;
    if (obs != 2) begin
      bad++; $display("FAIL post_reset_count got=%0d want=2", obs);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_pkt_hold();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
